collision_scheduler: RTL

Per-frame collision event scheduler between the pixel-rate collision detector and the game-state logic (score, monkey physics, fruit removal). It condenses any number of per-pixel collision hits within one video frame into at most one event per source. At each start of frame it snapshots those sticky flags. It then dispatches them one at a time, in fixed priority, over a valid/ready handshake.

---
 rtl/collision_pkg.sv | 22 ++
 rtl/collision_prio_enc.sv | 34 +++
 rtl/collision_scheduler.sv | 104 ++++++++++
 3 files changed

// File: rtl/collision_pkg.sv
// Shared types and constants for the collision event scheduler.
package collision_pkg;

  // Event kind presented to the game-state logic.
  typedef enum logic [1:0] {
    EVT_WALL  = 2'd0,
    EVT_ROPE  = 2'd1,
    EVT_FRUIT = 2'd2
  } evt_type_t;

  localparam int DEFAULT_NUM_FRUITS = 5;
  localparam int DEFAULT_FIDX_W     = 3;

  // Internal collision vector layout: the lowest index is the highest
  // priority, so the encoder only has to isolate the lowest set bit.
  // Fruit i lives at FRUIT_BASE + i, which keeps wall/rope positions
  // independent of how many fruits are configured.
  localparam int WALL_BIT   = 0;
  localparam int ROPE_BIT   = 1;
  localparam int FRUIT_BASE = 2;

endpackage

// File: rtl/collision_prio_enc.sv
// Fixed-priority encoder over the pending vector: wall > rope > fruit0 > ...
module collision_prio_enc
  import collision_pkg::*;
#(
  parameter  int NUM_FRUITS = DEFAULT_NUM_FRUITS,
  parameter  int FIDX_W     = DEFAULT_FIDX_W,
  localparam int VEC_W      = NUM_FRUITS + FRUIT_BASE
) (
  input  logic [VEC_W-1:0]  pending,
  output logic              any,
  output logic [1:0]        evt_type,
  output logic [FIDX_W-1:0] fruit_idx,
  output logic [VEC_W-1:0]  one_hot
);

  assign any     = |pending;
  // Two's-complement trick isolates the lowest (highest-priority) set bit.
  assign one_hot = pending & (~pending + VEC_W'(1));

  // Decode the selected bit into an event type and fruit index.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    evt_type  = EVT_WALL;
    fruit_idx = '0;
    if (one_hot[ROPE_BIT]) evt_type = EVT_ROPE;
    for (int i = 0; i < NUM_FRUITS; i++) begin
      if (one_hot[FRUIT_BASE+i]) begin
        evt_type  = EVT_FRUIT;
        fruit_idx = FIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/collision_scheduler.sv
// Per-frame collision scheduler: accumulates sticky pixel-rate hits,
// snapshots them at start of frame and dispatches one event per source
// over a valid/ready handshake in fixed priority.
module collision_scheduler
  import collision_pkg::*;
#(
  parameter int NUM_FRUITS = DEFAULT_NUM_FRUITS,
  parameter int FIDX_W     = DEFAULT_FIDX_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startOfFrame,
  input  logic                  enable,
  input  logic                  wallCollision,
  input  logic                  ropeCollision,
  input  logic [NUM_FRUITS-1:0] fruitCollision,
  input  logic                  evtReady,
  output logic                  evtValid,
  output logic [1:0]            evtType,
  output logic [FIDX_W-1:0]     evtFruit,
  output logic                  frameDone,
  output logic                  overrun
);

  localparam int VEC_W = NUM_FRUITS + FRUIT_BASE;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_DISPATCH = 1'b1;

  logic [VEC_W-1:0] accum;
  logic [VEC_W-1:0] pending;
  logic [VEC_W-1:0] hits;
  logic [VEC_W-1:0] one_hot;
  logic [VEC_W-1:0] ack_mask;
  logic [VEC_W-1:0] pending_kept;
  logic [VEC_W-1:0] pending_next;
  logic             handshake;
  logic             done_next;
  logic [0:0]       state;
  logic [0:0]       state_next;

  // Pause masks accumulation only; dispatch keeps running.
  assign hits = {fruitCollision, ropeCollision, wallCollision} & {VEC_W{enable}};

  collision_prio_enc #(
    .NUM_FRUITS (NUM_FRUITS),
    .FIDX_W     (FIDX_W)
  ) u_prio_enc (
    .pending   (pending),
    .any       (evtValid),
    .evt_type  (evtType),
    .fruit_idx (evtFruit),
    .one_hot   (one_hot)
  );

  // Handshake clear is applied before the snapshot merge, so an acked
  // bit cannot reappear through the OR with accum of the same frame.
  assign handshake    = evtValid && evtReady;
  assign ack_mask     = handshake ? one_hot : '0;
  assign pending_kept = pending & ~ack_mask;
  assign pending_next = startOfFrame ? (pending_kept | accum) : pending_kept;

  // FSM next state mirrors whether anything is left to dispatch.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (startOfFrame && (pending_next != '0)) state_next = ST_DISPATCH;
        if (startOfFrame && (pending_next == '0)) done_next = 1'b1;
      end
      default: begin
        if (pending_next == '0) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
    endcase
  end

  // Sticky hit collection; the start-of-frame cycle opens a new frame.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset)             accum <= '0;
    else if (startOfFrame) accum <= hits;
    else                   accum <= accum | hits;
  end

  // Dispatch vector, overrun flag, FSM and registered frameDone pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      overrun   <= 1'b0;
      state     <= ST_IDLE;
      frameDone <= 1'b0;
    end else begin
      pending   <= pending_next;
      state     <= state_next;
      frameDone <= done_next;
      if (startOfFrame && (pending_kept != '0)) overrun <= 1'b1;
    end
  end

endmodule
